m31_mul_arbiter: RTL and testbench
==================================

// Module: m31_mul_arbiter
// PURPOSE
//   Round-robin arbiter sharing one fully pipelined M31 multiplier (fixed latency, one issue/cycle)
//   between NUM_REQ requesters. Accepts operand pairs over valid/ready, registers the winner into
//   the multiplier, carries the requester id alongside in a tag pipeline, and returns each reduced
//   product tagged with its requester id. Sits between hash-round datapath lanes and the multiplier.
// PARAMETERS
//   NUM_REQ      4   number of requesters, 2..16
//   MUL_LATENCY  7   multiplier latency in cycles, mul_a/mul_b registered -> mul_out valid; >= 1
//   DATA_WIDTH   31  M31 element width; operands and products are canonical, < 2^31-1
//   ID_WIDTH     $clog2(NUM_REQ)  width of requester id
// PORTS
//   clk        in   1                    clock, all logic on rising edge
//   reset      in   1                    synchronous, active-high
//   req_valid  in   NUM_REQ              requester i holds an operand pair
//   req_ready  out  NUM_REQ              one-hot grant; at most one bit high per cycle
//   req_a      in   NUM_REQ*DATA_WIDTH   operand a, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_b      in   NUM_REQ*DATA_WIDTH   operand b, same packing
//   mul_a      out  DATA_WIDTH           operand a to multiplier
//   mul_b      out  DATA_WIDTH           operand b to multiplier
//   mul_out    in   DATA_WIDTH           reduced product from multiplier
//   rsp_valid  out  NUM_REQ              one-hot; bit i = result for requester i this cycle
//   rsp_id     out  ID_WIDTH             id of returning result
//   rsp_data   out  DATA_WIDTH           product a*b mod (2^31-1)
//   idle       out  1                    high when no operation is in flight
// BEHAVIOUR
//   - Reset: req_ready=0 during reset cycle, mul_a=mul_b=0, rsp_valid=0, rsp_id=0, rsp_data=0,
//     idle=1, rr pointer=0, tag pipeline valid bits all cleared.
//   - Arbitration (combinational from req_valid and rr pointer): scan from ptr upward, wrapping
//     at NUM_REQ-1 -> 0; first valid index wins; req_ready = one-hot of winner, 0 if none valid.
//     req_ready does not depend on any downstream state; no response backpressure exists.
//   - Handshake: fire = req_valid[i] & req_ready[i]. On fire at edge T: ptr <= winner+1 (mod
//     NUM_REQ); mul_a/mul_b <= winner's operands; issue stage tag {v=1,id=winner}. No fire:
//     ptr unchanged, issue tag v=0, mul_a/mul_b hold previous values.
//   - Requester must hold req_valid and operands stable until fire; dropping valid before grant
//     is permitted (no operation issued).
//   - Tag pipeline: MUL_LATENCY registered stages after the issue register, aligned so the tag
//     exits in the cycle mul_out carries that operand pair's product.
//   - Response: registered; rsp_valid[id] <= tag.v, rsp_id <= tag.id, rsp_data <= mul_out.
//     rsp_data/rsp_id hold last values when rsp_valid=0.
//   - Latency: fire at edge T -> rsp_valid high for exactly one cycle after edge T+MUL_LATENCY+1.
//     Throughput one result/cycle; results return in issue order.
//   - idle = no valid bit in issue register or tag stages.
//   - Reset mid-operation: all in-flight tags dropped; no rsp_valid for them after reset, even
//     though multiplier pipeline data still drains (ignored).
//   - Single requester held valid: granted every cycle (back-to-back), ptr wraps to it.
//   - Arbitration is fair: requester continuously valid granted within NUM_REQ cycles.
// TESTING
//   1. Req 0: a=3, b=5 single fire -> rsp_valid=4'b0001, rsp_id=0, rsp_data=15 MUL_LATENCY+1 edges later; idle 1->0->1.
//   2. All 4 valid continuously from reset -> grants 0,1,2,3,0,...; results return same id order, one/cycle.
//   3. a=b=2147483646 (p-1) on req 2 -> rsp_data=1; a=2^30, b=2 on req 3 -> rsp_data=1.
//   4. Req 1 and 3 valid, ptr=2 -> req 3 granted first, then 1; req 1 drops valid before grant -> no rsp for 1.
//   5. Fire 3 ops, assert reset 2 cycles later -> no rsp_valid ever for those ops; idle=1, ptr=0 after reset.
//   6. Random valid/operand traffic 10k cycles vs. scoreboard (a*b mod 2^31-1, id, order) -> zero mismatches, ready always one-hot or 0.

Source files
------------

// File: rtl/m31_mul_arbiter.sv
// Round-robin arbiter feeding one shared, fully pipelined M31 multiplier.
// A tag pipeline carries each requester id alongside its operand pair.
module m31_mul_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int MUL_LATENCY = 7,
   parameter int DATA_WIDTH  = 31,
   parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   output logic [DATA_WIDTH-1:0]         mul_a,
   output logic [DATA_WIDTH-1:0]         mul_b,
   input  logic [DATA_WIDTH-1:0]         mul_out,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [ID_WIDTH-1:0]           rsp_id,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          idle
);

   localparam int IW1 = ID_WIDTH + 1;

   logic [ID_WIDTH-1:0]    ptr;
   logic [ID_WIDTH-1:0]    winner;
   logic [IW1-1:0]         idx;
   logic                   found;
   logic                   fire;
   logic [MUL_LATENCY:0]   vld_p;
   logic [ID_WIDTH-1:0]    id_p [0:MUL_LATENCY];

   function automatic logic [ID_WIDTH-1:0] next_ptr(input logic [ID_WIDTH-1:0] w);
      return (w == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w + 1'b1;
   endfunction

   function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_WIDTH-1:0] id);
      logic [NUM_REQ-1:0] oh;
      oh     = '0;
      oh[id] = 1'b1;
      return oh;
   endfunction

   // Arbitration: first valid requester at or above ptr, wrapping around
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, ptr} + IW1'(k);
         if (idx >= IW1'(NUM_REQ)) idx = idx - IW1'(NUM_REQ);
         if (!found && req_valid[idx[ID_WIDTH-1:0]]) begin
            found  = 1'b1;
            winner = idx[ID_WIDTH-1:0];
         end
      end
      fire      = found & ~reset;
      req_ready = '0;
      if (fire) req_ready[winner] = 1'b1;
   end

   // Issue register (_p0), tag stages (_p1.._pN) and response register
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr       <= '0;
         vld_p     <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         rsp_valid <= '0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         vld_p     <= {vld_p[MUL_LATENCY-1:0], fire};
         rsp_valid <= vld_p[MUL_LATENCY] ? id_onehot(id_p[MUL_LATENCY]) : '0;
         if (fire) begin
            ptr   <= next_ptr(winner);
            mul_a <= req_a[winner*DATA_WIDTH +: DATA_WIDTH];
            mul_b <= req_b[winner*DATA_WIDTH +: DATA_WIDTH];
         end
         if (vld_p[MUL_LATENCY]) begin
            rsp_id   <= id_p[MUL_LATENCY];
            rsp_data <= mul_out;
         end
      end
   end

   // Tag ids are qualified by vld_p, so they need no reset
   always_ff @(posedge clk) begin
      id_p[0] <= winner;
      for (int k = 1; k <= MUL_LATENCY; k++) id_p[k] <= id_p[k-1];
   end

   assign idle = ~|vld_p;

endmodule

// File: tb/tb_m31_mul_arbiter.sv
// Directed and scoreboarded bench for m31_mul_arbiter with a behavioural
// M31 multiplier pipeline standing in for the real multiplier.
module tb_m31_mul_arbiter;
   localparam int NUM_REQ     = 4;
   localparam int MUL_LATENCY = 7;
   localparam int DATA_WIDTH  = 31;
   localparam int ID_WIDTH    = 2;
   localparam longint unsigned P = 64'd2147483647;
   localparam int N_RAND      = 10000;

   logic                          clk;
   logic                          reset;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
   logic [DATA_WIDTH-1:0]         mul_a;
   logic [DATA_WIDTH-1:0]         mul_b;
   logic [DATA_WIDTH-1:0]         mul_out;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [ID_WIDTH-1:0]           rsp_id;
   logic [DATA_WIDTH-1:0]         rsp_data;
   logic                          idle;

   int n_cmp = 0;
   int n_err = 0;

   m31_mul_arbiter #(
      .NUM_REQ(NUM_REQ), .MUL_LATENCY(MUL_LATENCY), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .idle(idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [30:0] mulmod(input logic [30:0] a, input logic [30:0] b);
      longint unsigned x;
      x = ({33'b0, a} * {33'b0, b}) % P;
      return x[30:0];
   endfunction

   // Behavioural multiplier: MUL_LATENCY registered stages
   logic [30:0] mpipe [MUL_LATENCY];
   always @(posedge clk) begin
      mpipe[0] <= mulmod(mul_a, mul_b);
      for (int k = 1; k < MUL_LATENCY; k++) mpipe[k] <= mpipe[k-1];
   end
   assign mul_out = mpipe[MUL_LATENCY-1];

   task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input int i, input logic v, input logic [30:0] a, input logic [30:0] b);
      req_valid[i] = v;
      req_a[i*DATA_WIDTH +: DATA_WIDTH] = a;
      req_b[i*DATA_WIDTH +: DATA_WIDTH] = b;
   endtask

   task automatic expect_rsp(input string tag, input int id, input longint unsigned data);
      check({tag, "_valid"}, rsp_valid, longint'(1) << id);
      check({tag, "_id"}, rsp_id, id);
      check({tag, "_data"}, rsp_data, data);
   endtask

   typedef struct {
      int          id;
      logic [30:0] data;
      int          due;
   } exp_t;

   exp_t              q[$];
   logic [NUM_REQ-1:0] v;
   logic [NUM_REQ-1:0] eg;
   int                 ptr_m;
   int                 g;
   int                 idx;
   logic               exp_v;

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;

      // Reset state, with a requester already valid
      set_req(0, 1'b1, 31'd3, 31'd5);
      tick();
      tick();
      check("rst_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_mul_a", mul_a, 0);
      check("rst_idle", idle, 1);

      // Single fire: 3*5 on requester 0
      reset = 1'b0;
      #1;
      check("t1_ready", req_ready, 4'b0001);
      check("t1_idle_pre", idle, 1);
      tick();
      req_valid = '0;
      check("t1_mul_a", mul_a, 3);
      check("t1_mul_b", mul_b, 5);
      check("t1_idle_busy", idle, 0);
      for (int k = 0; k < MUL_LATENCY; k++) begin
         tick();
         check("t1_early", rsp_valid, 0);
      end
      tick();
      expect_rsp("t1", 0, 15);
      check("t1_idle_post", idle, 1);
      tick();
      check("t1_single_cycle", rsp_valid, 0);
      check("t1_hold", rsp_data, 15);

      // All four valid continuously from reset
      reset = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 31'(i + 1), 31'(10 * (i + 1)));
      tick();
      reset = 1'b0;
      #1;
      for (int k = 0; k < 8; k++) begin
         check("t2_grant", req_ready, longint'(1) << (k % 4));
         tick();
      end
      req_valid = '0;
      for (int k = 0; k < 8; k++) begin
         tick();
         expect_rsp("t2", k % 4, 10 * (k % 4 + 1) * (k % 4 + 1));
      end
      tick();
      check("t2_done", rsp_valid, 0);

      // Field boundary operands
      set_req(2, 1'b1, 31'd2147483646, 31'd2147483646);
      set_req(3, 1'b1, 31'd1073741824, 31'd2);
      #1;
      check("t3_grant2", req_ready, 4'b0100);
      tick();
      req_valid[2] = 1'b0;
      #1;
      check("t3_mul_a_pm1", mul_a, 2147483646);
      check("t3_grant3", req_ready, 4'b1000);
      tick();
      req_valid[3] = 1'b0;
      check("t3_mul_a_2e30", mul_a, 1073741824);
      for (int k = 0; k < 6; k++) begin
         tick();
         check("t3_early", rsp_valid, 0);
      end
      tick();
      expect_rsp("t3_pm1", 2, 1);
      tick();
      expect_rsp("t3_2e31", 3, 1);

      // Pointer placement and withdrawal before grant
      set_req(1, 1'b1, 31'd6, 31'd7);
      #1;
      check("t4_grant1", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      set_req(1, 1'b1, 31'd8, 31'd9);
      set_req(3, 1'b1, 31'd11, 31'd13);
      #1;
      check("t4_ptr2_grant3", req_ready, 4'b1000);
      tick();
      req_valid[3] = 1'b0;
      #1;
      check("t4_then_grant1", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      set_req(0, 1'b1, 31'd5, 31'd5);
      set_req(1, 1'b1, 31'd20, 31'd21);
      #1;
      check("t4_wrap_grant0", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      #1;
      check("t4_withdrawn", req_ready, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t4_early", rsp_valid, 0);
      end
      tick();
      expect_rsp("t4_r1a", 1, 42);
      tick();
      expect_rsp("t4_r3", 3, 143);
      tick();
      expect_rsp("t4_r1b", 1, 72);
      tick();
      expect_rsp("t4_r0", 0, 25);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t4_no_withdrawn_rsp", rsp_valid, 0);
      end
      check("t4_idle", idle, 1);

      // Reset with three operations in flight (ptr currently 1)
      set_req(0, 1'b1, 31'd2, 31'd3);
      set_req(1, 1'b1, 31'd4, 31'd5);
      set_req(2, 1'b1, 31'd6, 31'd7);
      #1;
      check("t5_grant_a", req_ready, 4'b0010);
      tick();
      check("t5_grant_b", req_ready, 4'b0100);
      tick();
      check("t5_grant_c", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      tick();
      check("t5_busy", idle, 0);
      reset = 1'b1;
      tick();
      check("t5_idle_rst", idle, 1);
      check("t5_rv_rst", rsp_valid, 0);
      reset     = 1'b0;
      req_valid = 4'b1111;
      #1;
      check("t5_ptr0", req_ready, 4'b0001);
      req_valid = '0;
      #1;
      for (int k = 0; k < 12; k++) begin
         tick();
         check("t5_dropped", rsp_valid, 0);
      end
      check("t5_idle", idle, 1);

      // Random traffic against a scoreboard
      reset = 1'b1;
      tick();
      reset = 1'b0;
      ptr_m = 0;
      v     = '0;
      for (int cyc = 0; cyc < N_RAND + 20; cyc++) begin
         exp_v = (q.size() > 0) && (q[0].due == cyc);
         check("rand_rsp_valid", rsp_valid, exp_v ? (longint'(1) << q[0].id) : 0);
         if (exp_v) begin
            check("rand_rsp_id", rsp_id, q[0].id);
            check("rand_rsp_data", rsp_data, q[0].data);
            void'(q.pop_front());
         end
         if (cyc < N_RAND) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (!v[i] && $urandom_range(0, 2) == 0) begin
                  v[i] = 1'b1;
                  set_req(i, 1'b1, 31'($urandom % 32'h7fffffff), 31'($urandom % 32'h7fffffff));
               end
            end
         end
         req_valid = v;
         #1;
         g  = -1;
         eg = '0;
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = (ptr_m + k) % NUM_REQ;
            if (g < 0 && v[idx]) g = idx;
         end
         if (g >= 0) eg[g] = 1'b1;
         check("rand_grant", req_ready, eg);
         if (g >= 0) begin
            q.push_back('{id: g,
                          data: mulmod(req_a[g*DATA_WIDTH +: DATA_WIDTH], req_b[g*DATA_WIDTH +: DATA_WIDTH]),
                          due: cyc + MUL_LATENCY + 2});
            ptr_m = (g + 1) % NUM_REQ;
            v[g]  = 1'b0;
         end
         tick();
      end
      check("rand_drained", q.size(), 0);
      check("rand_idle", idle, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
